// File: rtl/cvrt_pkg.sv
// Shared constants and Gray/binary conversion helpers for the cvrt blocks.
// Helpers work on a 32-bit word; callers zero-extend and truncate to their width.
package cvrt_pkg;

    localparam int unsigned CVRT_DATA_WIDTH = 4;
    localparam int unsigned CVRT_MAX_WIDTH  = 32;

    typedef logic [CVRT_MAX_WIDTH-1:0] cvrt_word_t;

    function automatic cvrt_word_t f_bin2gry(input cvrt_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down, done as log2 shift/xor stages.
    function automatic cvrt_word_t f_gry2bin(input cvrt_word_t gry);
        cvrt_word_t bin;
        bin = gry;
        for (int unsigned s = 1; s < CVRT_MAX_WIDTH; s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

    // True when two or more bits are set: clearing the lowest set bit leaves a nonzero rest.
    function automatic logic f_multi_bit(input cvrt_word_t w);
        return (w & (w - cvrt_word_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/cvrt_gry2bin.sv
// Purely combinational Gray-to-binary converter, width-parameterised.
module cvrt_gry2bin
    import cvrt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CVRT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_gry,
    output logic [DATA_WIDTH-1:0] o_bin
);

    always_comb begin
        o_bin = DATA_WIDTH'(f_gry2bin(cvrt_word_t'(i_gry)));
    end

endmodule

// File: rtl/cvrt_bin2gry.sv
// Binary-to-Gray converter with registered output, reconversion self-check
// and a step-error flag for consecutive valid values differing in 2+ bits.
module cvrt_bin2gry
    import cvrt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CVRT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_bin,
    input  logic                  i_vld,
    output logic [DATA_WIDTH-1:0] o_gry,
    output logic [DATA_WIDTH-1:0] o_gry_reg,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_bin_chk,
    output logic                  o_err
);

    logic [DATA_WIDTH-1:0] gry_c;
    logic [DATA_WIDTH-1:0] diff_c;
    logic [DATA_WIDTH-1:0] gry_d,     gry_q;
    logic                  vld_d,     vld_q;
    logic                  err_d,     err_q;
    logic                  ref_vld_d, ref_vld_q;

    always_comb begin
        gry_c     = DATA_WIDTH'(f_bin2gry(cvrt_word_t'(i_bin)));
        diff_c    = gry_c ^ gry_q;
        gry_d     = gry_q;
        vld_d     = i_vld;
        err_d     = 1'b0;
        ref_vld_d = ref_vld_q;
        if (i_vld) begin
            gry_d     = gry_c;
            ref_vld_d = 1'b1;
            // No reference yet after reset, so the first sample can never flag.
            err_d     = ref_vld_q && f_multi_bit(cvrt_word_t'(diff_c));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gry_q     <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            ref_vld_q <= 1'b0;
        end else begin
            gry_q     <= gry_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            ref_vld_q <= ref_vld_d;
        end
    end

    cvrt_gry2bin #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_gry2bin (
        .i_gry(gry_q),
        .o_bin(o_bin_chk)
    );

    assign o_gry     = gry_c;
    assign o_gry_reg = gry_q;
    assign o_vld     = vld_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_cvrt_bin2gry.sv
// Directed self-checking bench for cvrt_bin2gry at the default 4-bit width.
module tb_cvrt_bin2gry;
    import cvrt_pkg::*;

    localparam int unsigned W = CVRT_DATA_WIDTH;

    localparam logic [3:0] GRAY_TBL [16] = '{
        4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
        4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8
    };

    logic         clk;
    logic         rst_n;
    logic [W-1:0] bin;
    logic         vld;
    logic [W-1:0] gry;
    logic [W-1:0] gry_reg;
    logic         vld_out;
    logic [W-1:0] bin_chk;
    logic         err;

    int checks = 0;
    int errors = 0;

    cvrt_bin2gry #(
        .DATA_WIDTH(W)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_bin    (bin),
        .i_vld    (vld),
        .o_gry    (gry),
        .o_gry_reg(gry_reg),
        .o_vld    (vld_out),
        .o_bin_chk(bin_chk),
        .o_err    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered outputs after the next edge: gry_reg, bin_chk, vld, err.
    task automatic step_regs(input string tag, input logic [3:0] e_gry, input logic [3:0] e_bin,
                             input logic e_vld, input logic e_err);
        @(posedge clk);
        #1;
        check({tag, "_gry_reg"}, 32'(gry_reg), 32'(e_gry));
        check({tag, "_bin_chk"}, 32'(bin_chk), 32'(e_bin));
        check({tag, "_vld"},     32'(vld_out), 32'(e_vld));
        check({tag, "_err"},     32'(err),     32'(e_err));
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = 1'b0;
        bin   = 4'd0;
        #3;
        check("rst_gry_reg", 32'(gry_reg), 32'd0);
        check("rst_vld",     32'(vld_out), 32'd0);
        check("rst_err",     32'(err),     32'd0);
        check("rst_bin_chk", 32'(bin_chk), 32'd0);
        bin = 4'b1011;
        #1;
        check("rst_comb_gry", 32'(gry), 32'b1110);
        @(posedge clk);
        #1;
        check("rst_hold_gry_reg", 32'(gry_reg), 32'd0);
        rst_n = 1'b1;

        // Walking sweep: every step is a single-bit Gray change, so no error.
        for (int k = 0; k < 16; k++) begin
            bin = 4'(k);
            vld = 1'b1;
            #1;
            check("sweep_comb", 32'(gry), 32'(GRAY_TBL[k]));
            step_regs("sweep", GRAY_TBL[k], 4'(k), 1'b1, 1'b0);
        end

        // 1011 -> 1110; previous 1000 differs in exactly two bits.
        bin = 4'b1011;
        #1;
        check("b1011_comb", 32'(gry), 32'b1110);
        step_regs("b1011", 4'b1110, 4'b1011, 1'b1, 1'b1);

        // 0 after 1110: three bits -> error.
        bin = 4'd0;
        step_regs("zero", 4'b0000, 4'd0, 1'b1, 1'b1);
        // Repeated value: no error.
        step_regs("repeat", 4'b0000, 4'd0, 1'b1, 1'b0);
        // 0 then 5: 0000 -> 0111, three bits.
        bin = 4'd5;
        step_regs("five", 4'b0111, 4'd5, 1'b1, 1'b1);

        // Idle three cycles with input toggling.
        vld = 1'b0;
        bin = 4'd3;
        #1;
        check("idle0_comb", 32'(gry), 32'b0010);
        step_regs("idle0", 4'b0111, 4'd5, 1'b0, 1'b0);
        bin = 4'd12;
        #1;
        check("idle1_comb", 32'(gry), 32'b1010);
        step_regs("idle1", 4'b0111, 4'd5, 1'b0, 1'b0);
        bin = 4'd9;
        #1;
        check("idle2_comb", 32'(gry), 32'b1101);
        step_regs("idle2", 4'b0111, 4'd5, 1'b0, 1'b0);

        // Wrap: 15 (1000 vs 0111, four bits) then 0 (single bit).
        vld = 1'b1;
        bin = 4'd15;
        step_regs("wrap15", 4'b1000, 4'd15, 1'b1, 1'b1);
        bin = 4'd0;
        step_regs("wrap0", 4'b0000, 4'd0, 1'b1, 1'b0);

        // Value 6 (0101 vs 0000, two bits), then reset mid-cycle.
        bin = 4'd6;
        step_regs("six", 4'b0101, 4'd6, 1'b1, 1'b1);
        vld = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_gry_reg", 32'(gry_reg), 32'd0);
        check("midrst_vld",     32'(vld_out), 32'd0);
        check("midrst_err",     32'(err),     32'd0);
        check("midrst_bin_chk", 32'(bin_chk), 32'd0);
        @(posedge clk);
        #1;
        // Release between edges with the first sample already presented.
        rst_n = 1'b1;
        bin   = 4'd9;
        vld   = 1'b1;
        step_regs("post_rst9", 4'b1101, 4'd9, 1'b1, 1'b0);
        bin = 4'd8;
        step_regs("post_rst8", 4'b1100, 4'd8, 1'b1, 1'b0);
        vld = 1'b0;
        step_regs("final_idle", 4'b1100, 4'd8, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
